// File: rtl/fifo_pkg.sv
// Shared types and constants for the packet-aware synchronous FIFO.
package fifo_pkg;

  localparam int OVF_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    BAD      = 2'd2
  } wr_state_e;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/sync_sdpram.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
module sync_sdpram #(
  parameter int WIDTH      = 9,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value whenever no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pkt_sync_fifo.sv
// Single-clock FIFO with optional store-and-forward frame mode:
// only committed frames become visible to the reader.
module pkt_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 10,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 5,
  parameter int PKT_MODE         = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_last,
  input  logic                     wr_drop,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [DEPTH_WIDTH:0]     wr_water_level,
  output logic [OVF_CNT_WIDTH-1:0] ovf_count,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  output logic                     rd_valid,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [DEPTH_WIDTH:0]     rd_water_level,
  output logic [DEPTH_WIDTH:0]     pkt_count
);

  localparam int PW = ptr_width(DEPTH_WIDTH);
  localparam logic [PW-1:0] DEPTH_WORDS = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [PW-1:0] PTR_ONE     = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0] AF_LEVEL    = PW'(ALMOST_FULL_NUM);
  localparam logic [PW-1:0] AE_LEVEL    = PW'(ALMOST_EMPTY_NUM);
  localparam logic [OVF_CNT_WIDTH-1:0] OVF_MAX = {OVF_CNT_WIDTH{1'b1}};
  localparam logic [OVF_CNT_WIDTH-1:0] OVF_ONE = {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [PW-1:0]            wr_ptr, commit_ptr, rd_ptr, pkt_cnt;
  logic [PW-1:0]            wr_level, rd_level;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt;
  wr_state_e                state, state_next;
  logic                     full, empty, rd_accept;
  logic                     ram_we, do_commit, do_restore, do_ovf, pkt_inc, pkt_dec;
  logic [DATA_WIDTH:0]      ram_rdata;

  assign wr_level  = wr_ptr - rd_ptr;
  assign rd_level  = commit_ptr - rd_ptr;
  assign full      = (wr_level == DEPTH_WORDS);
  assign empty     = (commit_ptr == rd_ptr);
  assign rd_accept = rd_en && !empty;
  assign pkt_inc   = (PKT_MODE == 0) ? (ram_we && wr_last) : do_commit;
  assign pkt_dec   = rd_valid && rd_last;

  // Write-side decision; drop outranks overflow, which outranks commit.
  always_comb begin
    ram_we     = 1'b0;
    do_commit  = 1'b0;
    do_restore = 1'b0;
    do_ovf     = 1'b0;
    state_next = state;
    if (PKT_MODE == 0) begin
      ram_we     = wr_en && !full;
      state_next = IDLE;
    end else if (wr_drop) begin
      do_restore = 1'b1;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, IN_FRAME: begin
          if (wr_en && full) begin
            state_next = BAD;
          end else if (wr_en) begin
            ram_we = 1'b1;
            if (wr_last) begin
              do_commit  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = IN_FRAME;
            end
          end else begin
            state_next = state;
          end
        end
        BAD: begin
          if (wr_en && wr_last) begin
            do_restore = 1'b1;
            do_ovf     = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = BAD;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Pointers, write FSM state, read-valid and the frame/overflow counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= {PW{1'b0}};
      commit_ptr <= {PW{1'b0}};
      rd_ptr     <= {PW{1'b0}};
      pkt_cnt    <= {PW{1'b0}};
      ovf_cnt    <= {OVF_CNT_WIDTH{1'b0}};
      state      <= IDLE;
      rd_valid   <= 1'b0;
    end else begin
      state <= state_next;
      if (do_restore) begin
        wr_ptr <= commit_ptr;
      end else if (ram_we) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      // In plain mode every accepted word is immediately readable.
      if (PKT_MODE == 0) begin
        commit_ptr <= ram_we ? (wr_ptr + PTR_ONE) : wr_ptr;
      end else if (do_commit) begin
        commit_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      rd_valid <= rd_accept;
      if (do_ovf && (ovf_cnt != OVF_MAX)) begin
        ovf_cnt <= ovf_cnt + OVF_ONE;
      end
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  sync_sdpram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wr_ptr[DEPTH_WIDTH-1:0]),
    .wdata ({wr_last, wr_data}),
    .re    (rd_accept),
    .raddr (rd_ptr[DEPTH_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign rd_data        = ram_rdata[DATA_WIDTH-1:0];
  assign rd_last        = ram_rdata[DATA_WIDTH];
  assign wr_full        = full;
  assign rd_empty       = empty;
  assign wr_water_level = wr_level;
  assign rd_water_level = rd_level;
  assign almost_full    = (wr_level >= AF_LEVEL);
  assign almost_empty   = (rd_level <= AE_LEVEL);
  assign pkt_count      = pkt_cnt;
  assign ovf_count      = ovf_cnt;

endmodule

// File: tb/tb_pkt_sync_fifo.sv
// Directed bench: a plain-mode and a frame-mode instance share one stimulus stream.
module tb_pkt_sync_fifo;

  logic       clk = 1'b0;
  logic       rst, wr_en, wr_last, wr_drop, rd_en;
  logic [7:0] wr_data;

  logic        p_wr_full, p_af, p_rd_last, p_rd_valid, p_rd_empty, p_ae;
  logic [7:0]  p_rd_data;
  logic [4:0]  p_wl, p_rl, p_pc;
  logic [15:0] p_ovf;
  logic        f_wr_full, f_af, f_rd_last, f_rd_valid, f_rd_empty, f_ae;
  logic [7:0]  f_rd_data;
  logic [4:0]  f_wl, f_rl, f_pc;
  logic [15:0] f_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pkt_sync_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                  .ALMOST_EMPTY_NUM(2), .PKT_MODE(0)) u_plain (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_drop(wr_drop), .wr_full(p_wr_full), .almost_full(p_af),
    .wr_water_level(p_wl), .ovf_count(p_ovf), .rd_en(rd_en), .rd_data(p_rd_data),
    .rd_last(p_rd_last), .rd_valid(p_rd_valid), .rd_empty(p_rd_empty),
    .almost_empty(p_ae), .rd_water_level(p_rl), .pkt_count(p_pc));

  pkt_sync_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14),
                  .ALMOST_EMPTY_NUM(2), .PKT_MODE(1)) u_frame (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_drop(wr_drop), .wr_full(f_wr_full), .almost_full(f_af),
    .wr_water_level(f_wl), .ovf_count(f_ovf), .rd_en(rd_en), .rd_data(f_rd_data),
    .rd_last(f_rd_last), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
    .almost_empty(f_ae), .rd_water_level(f_rl), .pkt_count(f_pc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_last = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    chk("rst_p_full",   32'(p_wr_full),  32'd0);
    chk("rst_p_empty",  32'(p_rd_empty), 32'd1);
    chk("rst_p_ae",     32'(p_ae),       32'd1);
    chk("rst_p_af",     32'(p_af),       32'd0);
    chk("rst_p_valid",  32'(p_rd_valid), 32'd0);
    chk("rst_p_data",   32'(p_rd_data),  32'd0);
    chk("rst_f_pkt",    32'(f_pc),       32'd0);
    chk("rst_f_ovf",    32'(f_ovf),      32'd0);
    rst = 1'b0;

    // ---- plain mode: fill 16, reject the 17th, drain in order ----
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("fill_full",  32'(p_wr_full),  32'd1);
    chk("fill_level", 32'(p_wl),       32'd16);
    chk("fill_af",    32'(p_af),       32'd1);
    chk("fill_ae",    32'(p_ae),       32'd0);
    chk("fill_empty", 32'(p_rd_empty), 32'd0);
    wr_en = 1'b1; wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("ovr_level", 32'(p_wl), 32'd16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_valid", 32'(p_rd_valid), 32'd1);
      chk("drain_data",  32'(p_rd_data),  32'(i));
      if (i == 0) chk("full_release", 32'(p_wr_full), 32'd0);
    end
    chk("drain_empty", 32'(p_rd_empty), 32'd1);
    step();
    chk("empty_rd_valid", 32'(p_rd_valid), 32'd0);
    chk("empty_rd_hold",  32'(p_rd_data),  32'h0F);
    chk("empty_rd_level", 32'(p_rl),       32'd0);
    rd_en = 1'b0;

    // ---- plain mode: half-full steady state across the wrap ----
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 64; k++) begin
      wr_data = 8'(8'h48 + k);
      step();
      chk("steady_data",  32'(p_rd_data),  32'(8'h40 + k));
      chk("steady_valid", 32'(p_rd_valid), 32'd1);
      chk("steady_level", 32'(p_wl),       32'd8);
    end
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // ---- frame mode: 5-word frame becomes visible only after commit ----
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i); wr_last = (i == 4);
      step();
      if (i < 4) chk("frm_hidden", 32'(f_rd_empty), 32'd1);
    end
    idle_inputs();
    chk("frm_visible", 32'(f_rd_empty), 32'd0);
    chk("frm_pkt",     32'(f_pc),       32'd1);
    chk("frm_rlevel",  32'(f_rl),       32'd5);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("frm_rd_data", 32'(f_rd_data), 32'(8'h10 + i));
      chk("frm_rd_last", 32'(f_rd_last), 32'(i == 4));
    end
    rd_en = 1'b0;
    step();
    chk("frm_pkt_done", 32'(f_pc),       32'd0);
    chk("frm_empty",    32'(f_rd_empty), 32'd1);

    // ---- frame mode: drop an uncommitted frame ----
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      step();
    end
    wr_en = 1'b0;
    chk("drop_pre_wl", 32'(f_wl), 32'd3);
    wr_drop = 1'b1;
    step();
    chk("drop_wl",    32'(f_wl),       32'd0);
    chk("drop_empty", 32'(f_rd_empty), 32'd1);
    chk("drop_pkt",   32'(f_pc),       32'd0);
    chk("drop_ovf",   32'(f_ovf),      32'd0);
    wr_en = 1'b1; wr_last = 1'b1; wr_data = 8'h77;
    step();
    idle_inputs();
    chk("drop_word_wl",  32'(f_wl), 32'd0);
    chk("drop_word_pkt", 32'(f_pc), 32'd0);

    // ---- frame mode: 20-word frame overflows a 16-deep FIFO ----
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i); wr_last = (i == 19);
      step();
      if (i == 15) chk("ovf_full", 32'(f_wr_full), 32'd1);
    end
    idle_inputs();
    chk("ovf_count", 32'(f_ovf),      32'd1);
    chk("ovf_empty", 32'(f_rd_empty), 32'd1);
    chk("ovf_wl",    32'(f_wl),       32'd0);
    chk("ovf_nfull", 32'(f_wr_full),  32'd0);
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i); wr_last = (i == 3);
      step();
    end
    idle_inputs();
    chk("post_ovf_pkt", 32'(f_pc), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_ovf_data", 32'(f_rd_data), 32'(8'hC0 + i));
      chk("post_ovf_last", 32'(f_rd_last), 32'(i == 3));
    end
    rd_en = 1'b0;

    // ---- frame mode: reset mid-frame with two committed frames ----
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h21 + i); wr_last = (i == 1) || (i == 3);
      step();
    end
    idle_inputs();
    chk("pre_rst_pkt", 32'(f_pc), 32'd2);
    chk("pre_rst_rl",  32'(f_rl), 32'd4);
    chk("pre_rst_wl",  32'(f_wl), 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(f_rd_empty), 32'd1);
    chk("mid_rst_pkt",   32'(f_pc),       32'd0);
    chk("mid_rst_wl",    32'(f_wl),       32'd0);
    chk("mid_rst_data",  32'(f_rd_data),  32'd0);
    chk("mid_rst_last",  32'(f_rd_last),  32'd0);
    chk("mid_rst_ovf",   32'(f_ovf),      32'd0);
    chk("mid_rst_ae",    32'(f_ae),       32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h51 + i); wr_last = (i == 2);
      step();
    end
    idle_inputs();
    chk("post_rst_pkt", 32'(f_pc), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_data", 32'(f_rd_data), 32'(8'h51 + i));
      chk("post_rst_last", 32'(f_rd_last), 32'(i == 2));
    end
    rd_en = 1'b0;
    step();
    chk("post_rst_done", 32'(f_pc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
